// File: rtl/proc_trace_pkg.sv
// proc_trace_pkg: shared trace entry types, widths and capture canonicalisation
package proc_trace_pkg;
    localparam int TRACE_SEQ_W = 16;
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] inst;
        logic        wen;
        logic [4:0]  wreg;
        logic [31:0] wdata;
    } trace_payload_t;
    typedef struct packed {
        logic [TRACE_SEQ_W-1:0] seq;
        trace_payload_t         payload;
    } trace_entry_t;
    localparam int TRACE_PAYLOAD_W = $bits(trace_payload_t);
    localparam int TRACE_ENTRY_W   = $bits(trace_entry_t);
    // A non-writing instruction carries no destination; x0 never holds data.
    function automatic trace_payload_t canon_entry(
        input logic [31:0] addr,
        input logic [31:0] inst,
        input logic        wen,
        input logic [4:0]  wreg,
        input logic [31:0] wdata
    );
        trace_payload_t p;
        p.addr  = addr;
        p.inst  = inst;
        p.wen   = wen;
        p.wreg  = wen ? wreg : 5'd0;
        p.wdata = (wen && wreg != 5'd0) ? wdata : 32'd0;
        return p;
    endfunction
endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: DEPTH x WIDTH synchronous FIFO with push/pop/clear and occupancy count.
// Ports: clk, rst (async active-low), clear (sync flush), push/wdata, pop/rdata
// (rdata reads 0 when empty), count, empty, full.
module trace_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;
    assign empty   = count_q == '0;
    assign full    = count_q == (AW+1)'(DEPTH);
    assign do_pop  = pop & ~empty;
    // When full, a same-cycle pop frees the slot the write lands in.
    assign do_push = push & (~full | do_pop);
    always_comb begin
        wr_d    = clear ? '0 : wr_q + AW'(do_push);
        rd_d    = clear ? '0 : rd_q + AW'(do_pop);
        count_d = clear ? '0 : count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem_q[wr_q] <= wdata;
    end
    // Masking keeps stale or uninitialised storage off the outputs when empty.
    assign rdata = empty ? '0 : mem_q[rd_q];
    assign count = count_q;
endmodule

// File: rtl/proc_trace_buffer.sv
// proc_trace_buffer: sequence-stamps processor retirements into a FIFO drained over val/rdy.
// Ports: clk, rst (async active-low), en (capture enable), clear (sync flush),
// trace_* (retirement input), out_* with out_val/out_rdy (head entry stream),
// count (occupancy), drop_count (saturating overflow drops).
module proc_trace_buffer
    import proc_trace_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int SEQ_W = TRACE_SEQ_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   clear,
    input  logic                   trace_val,
    input  logic [31:0]            trace_addr,
    input  logic [31:0]            trace_inst,
    input  logic                   trace_wen,
    input  logic [4:0]             trace_wreg,
    input  logic [31:0]            trace_wdata,
    output logic                   out_val,
    input  logic                   out_rdy,
    output logic [SEQ_W-1:0]       out_seq,
    output logic [31:0]            out_addr,
    output logic [31:0]            out_inst,
    output logic                   out_wen,
    output logic [4:0]             out_wreg,
    output logic [31:0]            out_wdata,
    output logic [$clog2(DEPTH):0] count,
    output logic [SEQ_W-1:0]       drop_count
);
    localparam int W = SEQ_W + TRACE_PAYLOAD_W;
    logic [SEQ_W-1:0] seq_q, seq_d, drop_q, drop_d;
    logic             capture, pop, full, empty;
    logic [W-1:0]     head;
    trace_payload_t   cap_entry;
    assign capture   = trace_val & en;
    assign pop       = out_val & out_rdy;
    assign cap_entry = canon_entry(trace_addr, trace_inst, trace_wen, trace_wreg, trace_wdata);
    // Dropped retirements still consume a sequence number so gaps show the loss.
    always_comb begin
        seq_d  = clear ? '0 : seq_q + SEQ_W'(capture);
        drop_d = clear ? '0 : (capture & full & ~pop & ~&drop_q) ? drop_q + SEQ_W'(1) : drop_q;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seq_q  <= '0;
            drop_q <= '0;
        end else begin
            seq_q  <= seq_d;
            drop_q <= drop_d;
        end
    end
    trace_fifo #(.DEPTH(DEPTH), .WIDTH(W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .push  (capture),
        .pop   (pop),
        .wdata ({seq_q, cap_entry}),
        .rdata (head),
        .count (count),
        .empty (empty),
        .full  (full)
    );
    assign out_val = ~empty;
    assign {out_seq, out_addr, out_inst, out_wen, out_wreg, out_wdata} = head;
    assign drop_count = drop_q;
endmodule

// File: tb/tb_proc_trace_buffer.sv
// tb_proc_trace_buffer: scoreboard bench for proc_trace_buffer against a queue-based reference model
module tb_proc_trace_buffer;
    localparam int DEPTH = 8;
    typedef struct packed {
        logic [15:0] seq;
        logic [31:0] addr;
        logic [31:0] inst;
        logic        wen;
        logic [4:0]  wreg;
        logic [31:0] wdata;
    } exp_t;

    logic        clk = 0, rst = 0, en = 1, clear = 0;
    logic        trace_val = 0, trace_wen = 0, out_rdy = 0;
    logic [31:0] trace_addr = 0, trace_inst = 0, trace_wdata = 0;
    logic [4:0]  trace_wreg = 0;
    logic        out_val, out_wen;
    logic [15:0] out_seq, drop_count;
    logic [31:0] out_addr, out_inst, out_wdata;
    logic [4:0]  out_wreg;
    logic [3:0]  count;

    int vectors = 0, miscompares = 0;
    exp_t sb[$];
    int mocc = 0;
    logic [15:0] mseq = 0, mdrop = 0;

    proc_trace_buffer #(.DEPTH(DEPTH), .SEQ_W(16)) dut (
        .clk(clk), .rst(rst), .en(en), .clear(clear),
        .trace_val(trace_val), .trace_addr(trace_addr), .trace_inst(trace_inst),
        .trace_wen(trace_wen), .trace_wreg(trace_wreg), .trace_wdata(trace_wdata),
        .out_val(out_val), .out_rdy(out_rdy), .out_seq(out_seq), .out_addr(out_addr),
        .out_inst(out_inst), .out_wen(out_wen), .out_wreg(out_wreg), .out_wdata(out_wdata),
        .count(count), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] s, input logic [31:0] a, i,
                                input logic w, input logic [4:0] r, input logic [31:0] d);
        exp_t e;
        e.seq = s; e.addr = a; e.inst = i; e.wen = w;
        e.wreg  = w ? r : 5'd0;
        e.wdata = (w && r != 0) ? d : 32'd0;
        return e;
    endfunction

    // Reference model: tracks occupancy and counters, pushes expected entries.
    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            sb.delete(); mocc = 0; mseq = 0; mdrop = 0;
        end else if (clear) begin
            sb.delete(); mocc = 0; mseq = 0; mdrop = 0;
        end else begin
            bit pop, cap;
            pop = mocc > 0 && out_rdy;
            cap = trace_val && en;
            if (pop) mocc--;
            if (cap) begin
                if (mocc < DEPTH) begin
                    sb.push_back(mk(mseq, trace_addr, trace_inst, trace_wen, trace_wreg, trace_wdata));
                    mocc++;
                end else if (mdrop != 16'hffff) mdrop++;
                mseq++;
            end
        end
    end

    // Monitor: compares the presented head with the scoreboard and retires it on handshake.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            chk("rst_out_val", out_val, 0);
            chk("rst_count", count, 0);
        end else begin
            chk("out_val", out_val, mocc > 0);
            chk("count", count, mocc);
            chk("drop_count", drop_count, mdrop);
            if (out_val) begin
                if (sb.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL unexpected_entry: got seq %0h with nothing expected", out_seq);
                end else begin
                    chk("entry", {out_seq, out_addr, out_inst, out_wen, out_wreg, out_wdata}, sb[0]);
                    if (out_rdy) void'(sb.pop_front());
                end
            end
        end
    end

    task automatic step(input logic tv, input logic [31:0] a, i, input logic w,
                        input logic [4:0] r, input logic [31:0] d, input logic rdy);
        trace_val = tv; trace_addr = a; trace_inst = i;
        trace_wen = w; trace_wreg = r; trace_wdata = d; out_rdy = rdy;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n, input logic rdy);
        repeat (n) step(0, $urandom, $urandom, 1'($urandom), 5'($urandom), $urandom, rdy);
    endtask

    task automatic do_clear(input logic tv);
        clear = 1;
        step(tv, 32'h40, 32'h13, 1, 5'd3, 32'h99, 0);
        clear = 0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1;
        idle(2, 1);
        // addi x1,x0,5 at 0x000
        step(1, 32'h0, 32'h00500093, 1, 5'd1, 32'h5, 1);
        idle(3, 1);
        // overflow: 10 retirements into an 8-deep FIFO with no consumer
        do_clear(0);
        for (int k = 0; k < 10; k++) step(1, 32'(4*k), $urandom, 1, 5'($urandom_range(1, 31)), $urandom, 0);
        // full + pop + push in the same cycle
        step(1, 32'h100, 32'h00100113, 1, 5'd2, 32'h1, 1);
        idle(12, 1);
        // sw (no writeback) and addi x0
        step(1, 32'h10, 32'h00a12023, 0, 5'd10, 32'hdeadbeef, 1);
        step(1, 32'h14, 32'h00700013, 1, 5'd0, 32'h7, 1);
        idle(4, 1);
        // clear with a concurrent capture
        for (int k = 0; k < 3; k++) step(1, 32'(32'h200 + 4*k), $urandom, 1, 5'd4, $urandom, 0);
        do_clear(1);
        idle(1, 0);
        step(1, 32'h300, 32'h00000013, 1, 5'd5, 32'h55, 1);
        idle(3, 1);
        // async reset mid-stream
        for (int k = 0; k < 5; k++) step(1, 32'(32'h400 + 4*k), $urandom, 1, 5'd6, $urandom, 0);
        for (int k = 0; k < 3; k++) idle(1, 1'(k));
        #2 rst = 0;
        #1;
        chk("async_out_val", out_val, 0);
        chk("async_count", count, 0);
        @(posedge clk); #2 rst = 1;
        step(1, 32'h500, 32'h00100093, 1, 5'd1, 32'h1, 1);
        idle(3, 1);
        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            en = ($urandom_range(0, 9) != 0);
            clear = ($urandom_range(0, 63) == 0);
            step(1'($urandom), $urandom, $urandom, 1'($urandom), 5'($urandom),
                 $urandom, $urandom_range(0, 3) != 0);
        end
        en = 1; clear = 0;
        idle(12, 1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/proc_trace_buffer.md
Name: proc_trace_buffer

Overview:
- Sits directly downstream of the TinyRV1 processor and consumes its per-instruction retirement trace (trace_val/addr/inst/wen/wreg/wdata).
- Stamps each retired instruction with a sequence number and stores it in a DEPTH-entry FIFO.
- Drains the FIFO over a val/rdy stream to a debug consumer (UART or test harness), so trace output no longer depends on simulation-only printing.
- Counts instructions dropped on overflow; drops are also visible as gaps in the sequence numbers.

Parameters:
- DEPTH, 8, number of FIFO entries; must be a power of two, at least 2.
- SEQ_W, 16, width of the retirement sequence number and of the drop counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low; rst=0 resets all state.
- en  in  1  capture enable; when 0, retirements are neither stored nor counted.
- clear  in  1  synchronous flush: empties FIFO, zeroes seq and drop counters.
- trace_val  in  1  processor retired an instruction this cycle.
- trace_addr  in  32  PC of retired instruction.
- trace_inst  in  32  instruction word.
- trace_wen  in  1  instruction writes the register file.
- trace_wreg  in  5  destination register.
- trace_wdata  in  32  writeback data.
- out_val  out  1  head entry valid.
- out_rdy  in  1  consumer accepts head entry.
- out_seq  out  SEQ_W  sequence number of head entry.
- out_addr  out  32  head PC.
- out_inst  out  32  head instruction.
- out_wen  out  1  head write enable.
- out_wreg  out  5  head destination register.
- out_wdata  out  32  head writeback data.
- count  out  $clog2(DEPTH)+1  current occupancy.
- drop_count  out  SEQ_W  saturating count of dropped retirements.

Behaviour:
- Reset (rst=0, asynchronous): FIFO empty, out_val=0, count=0, seq=0, drop_count=0. All out_* data fields read 0 when empty.
- Capture: a retirement is trace_val=1 and en=1 sampled on a rising edge. It is assigned the current seq, then seq increments by 1 and wraps modulo 2^SEQ_W.
- Canonicalisation on capture:
  - if trace_wen=0, stored wreg=0 and wdata=0;
  - if trace_wen=1 and trace_wreg=0, stored wdata=0.
- Push condition: capture and (count<DEPTH, or a pop happens in the same cycle). If the FIFO is full and a pop occurs in the same cycle, the push is accepted and count stays at DEPTH.
- Drop: capture and full and no pop. The entry is discarded, seq still increments (leaving a gap), drop_count increments and saturates at 2^SEQ_W-1.
- Pop: out_val and out_rdy on the edge. The head advances and the new head is visible on the next cycle.
- Latency and bypass:
  - a captured entry appears on out_* the cycle after capture (1-cycle latency);
  - there is no combinational path from trace_* to out_*;
  - out_val must not depend combinationally on out_rdy.
- Simultaneous push and pop when non-empty: count unchanged, ordering preserved.
- Empty with capture: no bypass; out_val=0 this cycle and 1 next cycle.
- Pointers: log2(DEPTH)-bit read/write indices wrap naturally; full/empty come from count.
- clear=1: on that edge, FIFO empties, seq=0, drop_count=0. A capture in the same cycle is ignored; clear has priority over push, pop and drop.
- en=0 mid-stream: stored entries keep draining normally; seq holds its value.
- rst asserted mid-operation: all state is lost immediately; out_val falls asynchronously.
- Never emits X on out_* while out_val=1. X on trace_* while trace_val=0 must not propagate.

Decomposition:
- Shared package proc_trace_pkg:
  - typedef trace_entry_t as a packed struct {seq, addr, inst, wen, wreg, wdata};
  - TRACE_ENTRY_W constant;
  - function canon_entry implementing the canonicalisation rules.
- One sub-module, trace_fifo: generic DEPTH x WIDTH synchronous FIFO with push/pop/clear, count, and async active-low rst on pointers/count.
- proc_trace_buffer owns seq, drop logic, canonicalisation and stream signals.

Test Plan:
- Reset then retire addi x1,x0,5 at 0x000 (wen=1, wreg=1, wdata=5), out_rdy=1 -> next cycle out_val=1, seq=0, addr=0x000, wreg=1, wdata=0x5; one cycle later out_val=0, count=0.
- out_rdy=0, retire 10 instructions at 0x000..0x024 with DEPTH=8 -> count=8, drop_count=2; then drain with out_rdy=1 -> seqs 0..7 in order, addrs 0x000..0x01c.
- Full FIFO, out_rdy=1 and trace_val=1 in the same cycle -> drop_count unchanged, count stays 8, new entry emerges last with the next seq.
- Retire sw at 0x010 (wen=0, wdata=0xdeadbeef) and addi x0 (wen=1, wreg=0, wdata=7) -> stored wreg=0, wdata=0 for both; out_wen = 0 and 1 respectively.
- Three entries buffered, then clear=1 with trace_val=1 -> next cycle count=0, out_val=0, drop_count=0; next capture has seq=0.
- Five entries buffered, out_rdy toggling; assert rst=0 between clock edges -> out_val=0 and count=0 immediately, before the next clock edge; after release, first capture has seq=0.
